ltc2308_emulator: RTL

Synthesizable responder model of the LTC2308 12-bit SPI ADC. It is the device end of the link driven by adc_ltc2308.
- Watches CONVST/SCK/SDI from the master, runs a fixed-length conversion, and shifts the result out on SDO MSB-first.
- Captures the 6-bit config word from SDI for the next conversion.
- Used for loopback builds and for closed-loop benches of the ADC master; sample values come from a fabric-side source port.

---
 rtl/ltc2308_pkg.sv | 31 +++
 rtl/ltc2308_sync_edge.sv | 30 +++
 rtl/ltc2308_emulator.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/ltc2308_pkg.sv
// Shared types and constants for the LTC2308 responder model.
package ltc2308_pkg;

  localparam int DATA_BITS = 12;
  localparam int CFG_BITS  = 6;

  // Config word bit positions: {S/D, O/S, S1, S0, UNI, SLP}
  localparam int CFG_SD  = 5;
  localparam int CFG_OS  = 4;
  localparam int CFG_S1  = 3;
  localparam int CFG_S0  = 2;
  localparam int CFG_UNI = 1;
  localparam int CFG_SLP = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONV  = 2'd1,
    READ  = 2'd2,
    SLEEP = 2'd3
  } state_t;

  // Unipolar passes the offset-binary sample through; bipolar flips the MSB
  // to turn offset binary into two's complement.
  function automatic logic [DATA_BITS-1:0] to_output_code(
    input logic [DATA_BITS-1:0] sample,
    input logic                 uni
  );
    return uni ? sample : {~sample[DATA_BITS-1], sample[DATA_BITS-2:0]};
  endfunction

endpackage

// File: rtl/ltc2308_sync_edge.sv
// N-stage synchronizer for an asynchronous input with rise/fall pulses
// taken from the synchronized level.
module ltc2308_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Shift the input through the synchronizer and keep one more delayed copy
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign rise = sync_q[STAGES-1] & ~prev_q;
  assign fall = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/ltc2308_emulator.sv
// Device-side model of the LTC2308 12-bit SPI ADC: runs a fixed-length
// conversion on CONVST, shifts the result out on SDO MSB-first and captures
// the 6-bit config word on SDI for the next conversion.
// Optional: define LTC2308_EMU_SLEEP_EN to make the SLP config bit enter a
// sleep state after the frame (the next CONVST rise only wakes the device).
//
// Handshake: sample_req pulses for one cycle when a conversion starts;
// sample_cfg/sample_chan stay valid from that cycle until the next pulse.
// sample_data is captured on the last conversion cycle.
module ltc2308_emulator
  import ltc2308_pkg::*;
#(
  parameter int          CONV_CYCLES = 64,
  parameter int          SYNC_STAGES = 2,
  parameter logic [5:0]  CFG_RESET   = 6'b100010
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        CONVST,
  input  logic        SCK,
  input  logic        SDI,
  output logic        SDO,
  input  logic [11:0] sample_data,
  output logic [2:0]  sample_chan,
  output logic [5:0]  sample_cfg,
  output logic        sample_req,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  localparam int CNT_W = $clog2(CONV_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CONV_CYCLES - 1);

  state_t                state;
  logic [CNT_W-1:0]      cnt;
  logic [DATA_BITS-1:0]  shreg;
  logic [3:0]            bit_cnt;
  logic [2:0]            sdi_cnt;
  logic [CFG_BITS-1:0]   cfg_shift;
  logic [CFG_BITS-1:0]   cfg_next;
  logic [SYNC_STAGES-1:0] sdi_q;

  logic convst_rise, convst_fall, sck_rise, sck_fall;
  logic sdi_s;
  logic unused_convst_fall;

  ltc2308_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_convst (
    .clock   (clock),
    .reset_n (reset_n),
    .din     (CONVST),
    .rise    (convst_rise),
    .fall    (convst_fall)
  );

  ltc2308_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sck (
    .clock   (clock),
    .reset_n (reset_n),
    .din     (SCK),
    .rise    (sck_rise),
    .fall    (sck_fall)
  );

  assign unused_convst_fall = convst_fall;

  // SDI goes through the same depth as SCK so it is aligned with sck_rise
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) sdi_q <= '0;
    else          sdi_q <= {sdi_q[SYNC_STAGES-2:0], SDI};
  end
  assign sdi_s = sdi_q[SYNC_STAGES-1];

  // Config that takes effect when a frame ends or is aborted: only a full word
  logic [CFG_BITS-1:0] frame_cfg;
  logic [CFG_BITS-1:0] start_cfg;
  logic                start_conv;
  assign frame_cfg  = (sdi_cnt == 3'd6) ? cfg_shift : cfg_next;
  assign start_cfg  = (state == READ) ? frame_cfg : cfg_next;
  assign start_conv = convst_rise && ((state == IDLE) || (state == READ));

  // Main sequencer: conversion timing, readout shifting and config capture
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      shreg      <= '0;
      bit_cnt    <= '0;
      sdi_cnt    <= '0;
      cfg_shift  <= '0;
      cfg_next   <= CFG_RESET;
      sample_cfg <= CFG_RESET;
      sample_req <= 1'b0;
      busy       <= 1'b0;
    end else begin
      sample_req <= 1'b0;
      if (start_conv) begin
        // CONVST wins over any SCK edge on the same cycle
        state      <= CONV;
        cfg_next   <= start_cfg;
        sample_cfg <= start_cfg;
        sample_req <= 1'b1;
        busy       <= 1'b1;
        cnt        <= '0;
      end else begin
        case (state)
          CONV: begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_LAST) begin
              shreg   <= to_output_code(sample_data, sample_cfg[CFG_UNI]);
              busy    <= 1'b0;
              bit_cnt <= '0;
              sdi_cnt <= '0;
              state   <= READ;
            end
          end
          READ: begin
            if (sck_rise && (sdi_cnt < 3'd6)) begin
              cfg_shift <= {cfg_shift[CFG_BITS-2:0], sdi_s};
              sdi_cnt   <= sdi_cnt + 1'b1;
            end
            if (sck_fall) begin
              shreg   <= {shreg[DATA_BITS-2:0], 1'b0};
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == 4'd11) begin
                cfg_next <= frame_cfg;
`ifdef LTC2308_EMU_SLEEP_EN
                state    <= sample_cfg[CFG_SLP] ? SLEEP : IDLE;
`else
                state    <= IDLE;
`endif
              end
            end
          end
          SLEEP: begin
            if (convst_rise) state <= IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  assign SDO         = (state == READ) & shreg[DATA_BITS-1];
  assign sample_chan = {sample_cfg[CFG_S1], sample_cfg[CFG_S0], sample_cfg[CFG_OS]};
  assign dbg_state   = state;

endmodule
